// File: rtl/pe_mac_db.sv
// Weight-stationary signed MAC cell for a systolic array.
// It double-buffers the weight, forwards activations east and weights south, and emits partial sums L=MUL_LAT+1 cycles after issue.
module pe_mac_db #(
  parameter int DATA_W  = 16,
  parameter int ACC_W   = 32,
  parameter int MUL_LAT = 2,
  parameter int SAT_EN  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] i_left,
  input  logic              i_left_valid,
  input  logic [ACC_W-1:0]  i_top,
  input  logic              i_top_valid,
  input  logic [DATA_W-1:0] i_w,
  input  logic              i_wload,
  input  logic              i_swap,
  input  logic              i_ovf_clr,
  output logic [DATA_W-1:0] o_right,
  output logic              o_right_valid,
  output logic [ACC_W-1:0]  o_bot,
  output logic              o_bot_valid,
  output logic [DATA_W-1:0] o_w,
  output logic              o_wload,
  output logic              o_swap,
  output logic              o_ovf
);

  localparam int PW = 2 * DATA_W;

  logic signed [DATA_W-1:0] shadow_w;
  logic signed [DATA_W-1:0] active_w;
  logic signed [DATA_W-1:0] a_q;
  logic signed [DATA_W-1:0] w_q;
  logic signed [ACC_W-1:0]  add_q [MUL_LAT];
  logic                     lv_q  [MUL_LAT];
  logic                     tv_q  [MUL_LAT];
  logic signed [PW-1:0]     mul_raw;
  logic signed [PW-1:0]     prod_out;

  // Neighbour forwarding and the shadow/active weight pair; swap copies the pre-edge shadow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_right       <= '0;
      o_right_valid <= 1'b0;
      o_w           <= '0;
      o_wload       <= 1'b0;
      o_swap        <= 1'b0;
      shadow_w      <= '0;
      active_w      <= '0;
    end else begin
      o_right       <= i_left;
      o_right_valid <= i_left_valid;
      o_w           <= i_w;
      o_wload       <= i_wload;
      o_swap        <= i_swap;
      if (i_wload) shadow_w <= i_w;
      if (i_swap)  active_w <= shadow_w;
    end
  end

  // Issue stage latches operand and weight together, so a later swap cannot disturb an op in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q <= '0;
      w_q <= '0;
      for (int k = 0; k < MUL_LAT; k++) begin
        add_q[k] <= '0;
        lv_q[k]  <= 1'b0;
        tv_q[k]  <= 1'b0;
      end
    end else begin
      a_q      <= i_left;
      w_q      <= active_w;
      add_q[0] <= i_top_valid ? i_top : '0;
      lv_q[0]  <= i_left_valid;
      tv_q[0]  <= i_top_valid;
      for (int k = 1; k < MUL_LAT; k++) begin
        add_q[k] <= add_q[k-1];
        lv_q[k]  <= lv_q[k-1];
        tv_q[k]  <= tv_q[k-1];
      end
    end
  end

  assign mul_raw = PW'(a_q) * PW'(w_q);

  generate
    if (MUL_LAT == 1) begin : g_mul_comb
      assign prod_out = mul_raw;
    end else begin : g_mul_pipe
      logic signed [PW-1:0] prod_q [MUL_LAT-1];
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int k = 0; k < MUL_LAT-1; k++) prod_q[k] <= '0;
        end else begin
          prod_q[0] <= mul_raw;
          for (int k = 1; k < MUL_LAT-1; k++) prod_q[k] <= prod_q[k-1];
        end
      end
      assign prod_out = prod_q[MUL_LAT-2];
    end
  endgenerate

  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] add_l;
  logic signed [ACC_W-1:0] res;
  logic signed [ACC_W:0]   sum_w;
  logic                    lv_l;
  logic                    tv_l;
  logic                    ovf;

  // Overflow is read from the extra sum bit disagreeing with the ACC_W sign bit.
  always_comb begin
    lv_l     = lv_q[MUL_LAT-1];
    tv_l     = tv_q[MUL_LAT-1];
    add_l    = add_q[MUL_LAT-1];
    prod_ext = ACC_W'(prod_out);
    sum_w    = (ACC_W+1)'(add_l) + (ACC_W+1)'(prod_ext);
    ovf      = 1'b0;
    res      = add_l;
    if (lv_l) begin
      ovf = sum_w[ACC_W] ^ sum_w[ACC_W-1];
      res = sum_w[ACC_W-1:0];
      if (ovf && (SAT_EN != 0)) begin
        res = sum_w[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_bot       <= '0;
      o_bot_valid <= 1'b0;
      o_ovf       <= 1'b0;
    end else begin
      o_bot_valid <= lv_l | tv_l;
      if (lv_l | tv_l) o_bot <= res;
      if (ovf)            o_ovf <= 1'b1;
      else if (i_ovf_clr) o_ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pe_mac_db.sv
// Directed self-checking bench for pe_mac_db (MUL_LAT=2, so L=3).
// Two instances share stimulus: one saturating, one wrapping.
module tb_pe_mac_db;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] i_left;
  logic        i_left_valid;
  logic [31:0] i_top;
  logic        i_top_valid;
  logic [15:0] i_w;
  logic        i_wload;
  logic        i_swap;
  logic        i_ovf_clr;

  logic [15:0] o_right, wr_right;
  logic        o_right_valid, wr_right_valid;
  logic [31:0] o_bot, wr_bot;
  logic        o_bot_valid, wr_bot_valid;
  logic [15:0] o_w, wr_w;
  logic        o_wload, wr_wload;
  logic        o_swap, wr_swap;
  logic        o_ovf, wr_ovf;

  int cmp_count  = 0;
  int fail_count = 0;

  always #5 clk = ~clk;

  pe_mac_db #(.DATA_W(16), .ACC_W(32), .MUL_LAT(2), .SAT_EN(1)) dut (
    .clk(clk), .rst(rst),
    .i_left(i_left), .i_left_valid(i_left_valid),
    .i_top(i_top), .i_top_valid(i_top_valid),
    .i_w(i_w), .i_wload(i_wload), .i_swap(i_swap), .i_ovf_clr(i_ovf_clr),
    .o_right(o_right), .o_right_valid(o_right_valid),
    .o_bot(o_bot), .o_bot_valid(o_bot_valid),
    .o_w(o_w), .o_wload(o_wload), .o_swap(o_swap), .o_ovf(o_ovf)
  );

  pe_mac_db #(.DATA_W(16), .ACC_W(32), .MUL_LAT(2), .SAT_EN(0)) dut_wrap (
    .clk(clk), .rst(rst),
    .i_left(i_left), .i_left_valid(i_left_valid),
    .i_top(i_top), .i_top_valid(i_top_valid),
    .i_w(i_w), .i_wload(i_wload), .i_swap(i_swap), .i_ovf_clr(i_ovf_clr),
    .o_right(wr_right), .o_right_valid(wr_right_valid),
    .o_bot(wr_bot), .o_bot_valid(wr_bot_valid),
    .o_w(wr_w), .o_wload(wr_wload), .o_swap(wr_swap), .o_ovf(wr_ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_left = '0; i_left_valid = 1'b0; i_top = '0; i_top_valid = 1'b0;
    i_wload = 1'b0; i_swap = 1'b0; i_ovf_clr = 1'b0;
  endtask

  task automatic load_and_swap(input logic [15:0] w);
    i_w = w; i_wload = 1'b1;
    tick();
    i_wload = 1'b0; i_swap = 1'b1;
    tick();
    i_swap = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] zero16;
    zero16 = '0;
    rst = 1'b0;
    clear_inputs();
    i_w = '0;
    tick(); tick();
    cmp_count++;
    if (o_bot !== 32'd0 || o_bot_valid !== 1'b0) begin
      fail_count++; $display("[TB] FAIL reset_bot: bot=%h valid=%b want 0/0", o_bot, o_bot_valid);
    end
    cmp_count++;
    if (o_right !== zero16 || o_right_valid !== 1'b0 || o_w !== zero16 || o_wload !== 1'b0 || o_swap !== 1'b0) begin
      fail_count++; $display("[TB] FAIL reset_fwd: right=%h rv=%b w=%h wl=%b sw=%b want all 0", o_right, o_right_valid, o_w, o_wload, o_swap);
    end
    cmp_count++;
    if (o_ovf !== 1'b0) begin
      fail_count++; $display("[TB] FAIL reset_ovf: got %b want 0", o_ovf);
    end
    #3 rst = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    i_w = 16'd3; i_wload = 1'b1;
    tick();
    i_wload = 1'b0;
    cmp_count++;
    if (o_w !== 16'd3 || o_wload !== 1'b1) begin
      fail_count++; $display("[TB] FAIL chain_wload: o_w=%0d o_wload=%b want 3/1", o_w, o_wload);
    end
    i_swap = 1'b1;
    tick();
    i_swap = 1'b0;
    cmp_count++;
    if (o_swap !== 1'b1) begin
      fail_count++; $display("[TB] FAIL chain_swap: got %b want 1", o_swap);
    end
    i_left = 16'd5; i_left_valid = 1'b1; i_top = 32'd100; i_top_valid = 1'b1;
    tick();
    clear_inputs();
    cmp_count++;
    if (o_right !== 16'd5 || o_right_valid !== 1'b1) begin
      fail_count++; $display("[TB] FAIL basic_right: got %0d/%b want 5/1", o_right, o_right_valid);
    end
    cmp_count++;
    if (o_bot_valid !== 1'b0) begin
      fail_count++; $display("[TB] FAIL basic_early1: valid=%b want 0", o_bot_valid);
    end
    tick();
    cmp_count++;
    if (o_bot_valid !== 1'b0) begin
      fail_count++; $display("[TB] FAIL basic_early2: valid=%b want 0", o_bot_valid);
    end
    tick();
    cmp_count++;
    if (o_bot !== 32'd115 || o_bot_valid !== 1'b1) begin
      fail_count++; $display("[TB] FAIL basic_sum: got %0d/%b want 115/1", $signed(o_bot), o_bot_valid);
    end
    tick();
    cmp_count++;
    if (o_bot !== 32'd115 || o_bot_valid !== 1'b0) begin
      fail_count++; $display("[TB] FAIL basic_hold: got %0d/%b want 115/0", $signed(o_bot), o_bot_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_bot;
    logic        exp_v;
    load_and_swap(16'hFFFE);
    exp_bot = 32'd115;
    for (int i = 0; i < 8; i++) begin
      i_left = 16'(i + 1); i_left_valid = (i < 4);
      tick();
      exp_v = (i >= 2 && i <= 5);
      if (exp_v) exp_bot = 32'(-2 * (i - 1));
      cmp_count++;
      if (o_bot !== exp_bot || o_bot_valid !== exp_v) begin
        fail_count++; $display("[TB] FAIL b2b_%0d: got %0d/%b want %0d/%b", i, $signed(o_bot), o_bot_valid, $signed(exp_bot), exp_v);
      end
    end
    clear_inputs();
  endtask

  task automatic test_swap_midstream();
    logic [31:0] exp_bot;
    load_and_swap(16'd3);
    i_w = 16'd7;
    for (int i = 0; i < 8; i++) begin
      i_left = 16'd1; i_left_valid = (i < 6);
      i_wload = (i == 0); i_swap = (i == 2);
      tick();
      if (i >= 2) begin
        exp_bot = (i - 2 <= 2) ? 32'd3 : 32'd7;
        cmp_count++;
        if (o_bot !== exp_bot || o_bot_valid !== 1'b1) begin
          fail_count++; $display("[TB] FAIL swap_op%0d: got %0d/%b want %0d/1", i - 2, $signed(o_bot), o_bot_valid, exp_bot);
        end
      end
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_saturation();
    load_and_swap(16'd100);
    i_left = 16'd100; i_left_valid = 1'b1; i_top = 32'h7FFFFFF0; i_top_valid = 1'b1;
    tick();
    clear_inputs();
    tick(); tick();
    cmp_count++;
    if (o_bot !== 32'h7FFFFFFF || o_ovf !== 1'b1) begin
      fail_count++; $display("[TB] FAIL sat_pos: got %h ovf=%b want 7fffffff/1", o_bot, o_ovf);
    end
    cmp_count++;
    if (wr_bot !== 32'h80002700 || wr_ovf !== 1'b1) begin
      fail_count++; $display("[TB] FAIL wrap_pos: got %h ovf=%b want 80002700/1", wr_bot, wr_ovf);
    end
    i_left = 16'd1; i_left_valid = 1'b1;
    tick();
    clear_inputs();
    tick(); tick();
    cmp_count++;
    if (o_bot !== 32'd100 || o_ovf !== 1'b1 || wr_bot !== 32'd100 || wr_ovf !== 1'b1) begin
      fail_count++; $display("[TB] FAIL ovf_sticky: sat %0d/%b wrap %0d/%b want 100/1 both", o_bot, o_ovf, wr_bot, wr_ovf);
    end
    i_ovf_clr = 1'b1;
    tick();
    i_ovf_clr = 1'b0;
    cmp_count++;
    if (o_ovf !== 1'b0 || wr_ovf !== 1'b0) begin
      fail_count++; $display("[TB] FAIL ovf_clear: sat=%b wrap=%b want 0/0", o_ovf, wr_ovf);
    end
    i_left = 16'hFF9C; i_left_valid = 1'b1; i_top = 32'h80000000; i_top_valid = 1'b1;
    tick();
    clear_inputs();
    tick();
    i_ovf_clr = 1'b1;
    tick();
    cmp_count++;
    if (o_bot !== 32'h80000000 || o_ovf !== 1'b1) begin
      fail_count++; $display("[TB] FAIL sat_neg_setwins: got %h ovf=%b want 80000000/1", o_bot, o_ovf);
    end
    cmp_count++;
    if (wr_bot !== 32'h7FFFD8F0 || wr_ovf !== 1'b1) begin
      fail_count++; $display("[TB] FAIL wrap_neg_setwins: got %h ovf=%b want 7fffd8f0/1", wr_bot, wr_ovf);
    end
    tick();
    i_ovf_clr = 1'b0;
    cmp_count++;
    if (o_ovf !== 1'b0 || wr_ovf !== 1'b0) begin
      fail_count++; $display("[TB] FAIL ovf_clear2: sat=%b wrap=%b want 0/0", o_ovf, wr_ovf);
    end
  endtask

  task automatic test_passthrough();
    i_top = 32'd42; i_top_valid = 1'b1;
    tick();
    clear_inputs();
    cmp_count++;
    if (o_bot_valid !== 1'b0) begin
      fail_count++; $display("[TB] FAIL pass_early: valid=%b want 0", o_bot_valid);
    end
    tick(); tick();
    cmp_count++;
    if (o_bot !== 32'd42 || o_bot_valid !== 1'b1) begin
      fail_count++; $display("[TB] FAIL pass_value: got %0d/%b want 42/1", o_bot, o_bot_valid);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      cmp_count++;
      if (o_bot !== 32'd42 || o_bot_valid !== 1'b0) begin
        fail_count++; $display("[TB] FAIL idle_%0d: got %0d/%b want 42/0", i, o_bot, o_bot_valid);
      end
    end
  endtask

  task automatic test_reset_inflight();
    i_left = 16'd2; i_left_valid = 1'b1;
    tick();
    i_left = 16'd3;
    tick();
    clear_inputs();
    #2 rst = 1'b0;
    #1;
    cmp_count++;
    if (o_bot !== 32'd0 || o_bot_valid !== 1'b0 || o_ovf !== 1'b0) begin
      fail_count++; $display("[TB] FAIL rst_async_bot: bot=%h v=%b ovf=%b want 0", o_bot, o_bot_valid, o_ovf);
    end
    cmp_count++;
    if (o_right !== 16'd0 || o_right_valid !== 1'b0 || o_w !== 16'd0) begin
      fail_count++; $display("[TB] FAIL rst_async_fwd: right=%h rv=%b w=%h want 0", o_right, o_right_valid, o_w);
    end
    tick();
    #2 rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      cmp_count++;
      if (o_bot_valid !== 1'b0 || wr_bot_valid !== 1'b0) begin
        fail_count++; $display("[TB] FAIL rst_spurious_%0d: valid=%b/%b want 0", i, o_bot_valid, wr_bot_valid);
      end
    end
    i_left = 16'd5; i_left_valid = 1'b1; i_top = 32'd9; i_top_valid = 1'b1;
    tick();
    clear_inputs();
    tick(); tick();
    cmp_count++;
    if (o_bot !== 32'd9 || o_bot_valid !== 1'b1) begin
      fail_count++; $display("[TB] FAIL rst_weight0: got %0d/%b want 9/1", o_bot, o_bot_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_swap_midstream();
    test_saturation();
    test_passthrough();
    test_reset_inflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
    $finish;
  end

endmodule
